// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface ifetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Small synchronous prefetch FIFO; flush has priority over push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: issues word fetches, buffers responses in a
// prefetch FIFO and drives the IF/ID register, honouring stalls and redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  ifetch_unit_if.master       mem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                id_valid,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc4
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      addr_q;
  logic [31:0]      saved_target;
  logic [31:0]      target;
  logic             req;
  logic             ack_fire;
  logic             pending_no_ack;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     pop_entry;

  assign target         = word_align(redirect_pc);
  assign ack_fire       = req && mem.mem_ack;
  assign pending_no_ack = req && !mem.mem_ack;
  assign mem.mem_req    = req;
  assign mem.mem_addr   = addr_q;

  assign push_entry = '{instr: mem.mem_rdata, pc4: addr_q + PC_STEP};
  assign fifo_push  = (state == ISSUE) && ack_fire && !redirect_valid && !fifo_full;
  assign fifo_pop   = !redirect_valid && !stall && !fifo_empty;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (redirect_valid),
    .wr_data (push_entry),
    .rd_data (pop_entry),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = ISSUE;
      ISSUE:   if (redirect_valid && pending_no_ack) state_next = DISCARD;
      DISCARD: if (mem.mem_ack) state_next = ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Request only depends on registered state/count, so it cannot change
  // while a request waits for its ack (count only grows on an ack).
  always_comb begin
    req = 1'b0;
    unique case (state)
      IDLE:    req = 1'b0;
      ISSUE:   req = (fifo_count < CNT_W'(FIFO_DEPTH));
      DISCARD: req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // A redirect against an un-acked request parks the target until the
  // stale response has been absorbed; otherwise it takes effect at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= RESET_PC;
      saved_target <= RESET_PC;
    end else if (redirect_valid) begin
      if (pending_no_ack) saved_target <= target;
      else                addr_q       <= target;
    end else if (ack_fire) begin
      addr_q <= (state == DISCARD) ? saved_target : addr_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (!fifo_empty) begin
        id_valid <= 1'b1;
        id_instr <= pop_entry.instr;
        id_pc4   <= pop_entry.pc4;
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a configurable-latency memory responder.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;

  int unsigned lat = 0;
  int unsigned wait_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  ifetch_unit_if mem_bus ();

  ifetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem            (mem_bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc4         (id_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dw(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Memory: acks after 'lat' wait cycles, data derived from the address.
  assign mem_bus.mem_ack   = mem_bus.mem_req && (wait_cnt == lat);
  assign mem_bus.mem_rdata = dw(mem_bus.mem_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset)                                   wait_cnt <= 0;
    else if (mem_bus.mem_req && !mem_bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else                                          wait_cnt <= 0;
  end

  logic [97:0] obs;
  assign obs = {mem_bus.mem_req, mem_bus.mem_addr, id_valid, id_instr, id_pc4};

  task automatic cyc();
    @(negedge clk);
  endtask

  // Leaves reset released at a negedge; the following posedge is E1.
  task automatic do_reset(input int unsigned l);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    lat = l;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [97:0] exp;
    for (int c = 0; c < 2; c++) begin
      cyc();
      exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset c=%0d: got %h want %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [97:0] exp;
    do_reset(0);
    for (int c = 1; c <= 10; c++) begin
      cyc();
      exp = {1'b1, 32'(4 * (c - 1)), 1'(c >= 3),
             (c >= 3) ? dw(32'(4 * (c - 3))) : 32'h0,
             (c >= 3) ? 32'(4 * (c - 2)) : 32'h0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL zero_wait c=%0d: got %h want %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_latency();
    logic [97:0] exp;
    logic        v;
    do_reset(2);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      v = (c >= 5) && ((c - 5) % 3 == 0);
      exp = {1'b1, 32'(4 * ((c - 1) / 3)), v,
             v ? dw(32'(4 * ((c - 5) / 3))) : 32'h0,
             (c >= 5) ? 32'(4 * ((c - 5) / 3) + 4) : 32'h0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL latency c=%0d: got %h want %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [97:0] exp;
    do_reset(0);
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (c == 4)
        exp = {1'b1, 32'd12, 1'b1, dw(32'd4), 32'd8};
      else if (c >= 5 && c <= 9)
        exp = {1'b0, 32'd16, 1'b1, dw(32'd4), 32'd8};
      else
        exp = {1'b1, 32'(16 + 4 * (c - 10)), 1'b1,
               dw(32'(8 + 4 * (c - 10))), 32'(12 + 4 * (c - 10))};
      if (c >= 4) begin
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL stall c=%0d: got %h want %h", c, obs, exp);
        end
      end
      if (c == 4) stall = 1'b1;
      if (c == 9) stall = 1'b0;
    end
  endtask

  task automatic test_redirect_idle();
    logic [97:0] exp;
    do_reset(0);
    stall = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      case (c)
        3:       exp = {1'b0, 32'h08, 1'b0, 32'h0, 32'h0};
        4:       exp = {1'b1, 32'h1C, 1'b0, 32'h0, 32'h0};
        5:       exp = {1'b1, 32'h20, 1'b0, 32'h0, 32'h0};
        default: exp = {1'b1, 32'h24, 1'b1, dw(32'h1C), 32'h20};
      endcase
      if (c >= 3) begin
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL redirect_idle c=%0d: got %h want %h", c, obs, exp);
        end
      end
      if (c == 3) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_001F;
      end
      if (c == 4) begin
        redirect_valid = 1'b0;
        stall = 1'b0;
      end
    end
  endtask

  task automatic test_redirect_discard();
    logic [97:0] exp;
    do_reset(2);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c <= 9)
        exp = {1'b1, 32'h08, 1'b0, 32'h0, 32'h4};
      else if (c <= 12)
        exp = {1'b1, 32'h80, 1'b0, 32'h0, 32'h4};
      else if (c == 13)
        exp = {1'b1, 32'h84, 1'b0, 32'h0, 32'h4};
      else
        exp = {1'b1, 32'h84, 1'b1, dw(32'h80), 32'h84};
      if (c >= 7) begin
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL redirect_discard c=%0d: got %h want %h", c, obs, exp);
        end
      end
      if (c == 7) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
      end
      if (c == 8) redirect_pc = 32'h0000_0080;
      if (c == 9) redirect_valid = 1'b0;
    end
  endtask

  task automatic test_ack_stall_wrap();
    logic [97:0] exp;
    do_reset(0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      case (c)
        4:       exp = {1'b1, 32'h0000_000C, 1'b1, dw(32'h4), 32'h8};
        5:       exp = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h8};
        6:       exp = {1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h8};
        7:       exp = {1'b1, 32'h0000_0004, 1'b1, dw(32'hFFFF_FFFC), 32'h0};
        default: exp = {1'b1, 32'h0000_0008, 1'b1, dw(32'h0), 32'h4};
      endcase
      if (c >= 4) begin
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL ack_stall_wrap c=%0d: got %h want %h", c, obs, exp);
        end
      end
      if (c == 4) begin
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
      end
      if (c == 5) begin
        stall = 1'b0;
        redirect_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [97:0] exp;
    do_reset(2);
    for (int c = 1; c <= 6; c++) cyc();
    #2 reset = 1'b0;
    #1;
    exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h want %h", obs, exp);
    end
    do_reset(2);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      exp = {1'b1, 32'(4 * ((c - 1) / 3)), 1'(c == 5),
             (c == 5) ? dw(32'h0) : 32'h0, (c == 5) ? 32'h4 : 32'h0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_mid_restart c=%0d: got %h want %h", c, obs, exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_idle();
    test_redirect_discard();
    test_ack_stall_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
